// File: rtl/pipe_mem_pkg.sv
// Shared types and default widths for the IF/LSU memory port arbiter and the
// unified memory model it talks to.
package pipe_mem_pkg;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LSU  = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch
// and the load/store unit; LSU wins ties, a starvation counter protects IF.
module mem_port_arbiter #(
    parameter int ADDR_W       = pipe_mem_pkg::ADDR_W,
    parameter int DATA_W       = pipe_mem_pkg::DATA_W,
    parameter int STARVE_LIMIT = pipe_mem_pkg::STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_done,
    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [DATA_W/8-1:0]   lsu_be,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  lsu_done,
    output logic                  stall_if,
    output logic                  stall_lsu,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);
    import pipe_mem_pkg::*;

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
    logic                if_done_s, lsu_done_s;
    logic                starved_s;
    logic                grant_if_s;

    assign starved_s  = (starve_q == SW'(STARVE_LIMIT));
    assign grant_if_s = if_req & (~lsu_req | starved_s);

    // Next-state, arbitration and response routing
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        if_done_s   = 1'b0;
        lsu_done_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || lsu_req) begin
                    mem_req_d = 1'b1;
                    state_d   = ISSUE;
                    if (grant_if_s) begin
                        owner_d     = OWN_IF;
                        mem_we_d    = 1'b0;
                        mem_be_d    = {BE_W{1'b1}};
                        mem_addr_d  = if_addr;
                        mem_wdata_d = {DATA_W{1'b0}};
                        starve_d    = {SW{1'b0}};
                    end else begin
                        owner_d     = OWN_LSU;
                        mem_we_d    = lsu_we;
                        mem_be_d    = lsu_be;
                        mem_addr_d  = lsu_addr;
                        mem_wdata_d = lsu_wdata;
                        // LSU can only beat a waiting IF while below the limit,
                        // so this increment saturates by construction.
                        if (if_req) begin
                            starve_d = starve_q + SW'(1);
                        end else begin
                            starve_d = starve_q;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                    if (owner_q == OWN_IF) begin
                        if_done_s  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else if (owner_q == OWN_LSU) begin
                        lsu_done_s  = 1'b1;
                        lsu_rdata_d = mem_rdata;
                    end else begin
                        if_done_s  = 1'b0;
                        lsu_done_s = 1'b0;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d   = IDLE;
                owner_d   = OWN_NONE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and request-field registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            starve_q    <= {SW{1'b0}};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= {BE_W{1'b0}};
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            if_rdata_q  <= {DATA_W{1'b0}};
            lsu_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    // Done and read data are combinational on the response so the pipeline
    // can unstall in the same cycle the memory answers.
    assign if_done   = if_done_s;
    assign lsu_done  = lsu_done_s;
    assign if_rdata  = if_rdata_d;
    assign lsu_rdata = lsu_rdata_d;
    assign stall_if  = if_req & ~if_done_s;
    assign stall_lsu = lsu_req & ~lsu_done_s;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector and scoreboard bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    localparam int W_IF  = 1;
    localparam int W_LSU = 2;
    localparam int LIM   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        lsu_req;
    logic        lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        stall_if;
    logic        stall_lsu;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_be(lsu_be), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_rdata(lsu_rdata), .lsu_done(lsu_done),
        .stall_if(stall_if), .stall_lsu(stall_lsu),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    int          model_starve = 0;
    logic [31:0] last_if = 32'h0;
    logic [31:0] last_lsu = 32'h0;

    typedef struct {
        logic        use_if;
        logic        use_lsu;
        logic        we;
        logic [3:0]  be;
        logic [31:0] ia;
        logic [31:0] la;
        logic [31:0] wd;
        int          gd;
        int          rd;
        logic [31:0] rdat;
        int          exp_w;
        int          exp_lat;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, req_v);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_if_done"}, {31'h0, if_done}, 32'h0);
        chk({tag, "_lsu_done"}, {31'h0, lsu_done}, 32'h0);
        chk({tag, "_stall_if"}, {31'h0, stall_if}, {31'h0, if_req});
        chk({tag, "_stall_lsu"}, {31'h0, stall_lsu}, {31'h0, lsu_req});
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
        chk({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
        chk({tag, "_mem_be"}, {28'h0, mem_be}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk({tag, "_lsu_rdata"}, lsu_rdata, 32'h0);
        chk_quiet(tag);
    endtask

    // Called at a negedge right after the requests are driven with the DUT idle.
    task automatic serve(input int gd, input int rd, input logic [31:0] rdat,
                         input bit drop_in_wait, output int w, output int lat);
        int          t0;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        t0 = cyc;
        if (if_req && lsu_req) begin
            if (model_starve == LIM) begin
                w = W_IF;
                model_starve = 0;
            end else begin
                w = W_LSU;
                model_starve++;
            end
        end else if (if_req) begin
            w = W_IF;
            model_starve = 0;
        end else begin
            w = W_LSU;
        end
        if (w == W_IF) begin
            e_we = 1'b0; e_be = 4'hF; e_addr = if_addr; e_wd = 32'h0;
        end else begin
            e_we = lsu_we; e_be = lsu_be; e_addr = lsu_addr; e_wd = lsu_wdata;
        end
        @(negedge clk);
        chk("issue_mem_req", {31'h0, mem_req}, 32'h1);
        for (int i = 0; i <= gd; i++) begin
            if (i > 0) @(negedge clk);
            chk("issue_hold_req", {31'h0, mem_req}, 32'h1);
            chk("issue_addr", mem_addr, e_addr);
            chk("issue_we", {31'h0, mem_we}, {31'h0, e_we});
            if (w == W_LSU) begin
                chk("issue_be", {28'h0, mem_be}, {28'h0, e_be});
                chk("issue_wdata", mem_wdata, e_wd);
            end
            chk_quiet("issue");
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        if (drop_in_wait) begin
            if (w == W_IF) if_req = 1'b0;
            else lsu_req = 1'b0;
        end
        for (int i = 0; i < rd; i++) begin
            #1;
            chk("wait_mem_req", {31'h0, mem_req}, 32'h0);
            chk_quiet("wait");
            @(negedge clk);
        end
        mem_rvalid = 1'b1;
        mem_rdata = rdat;
        #1;
        chk("done_if", {31'h0, if_done}, (w == W_IF) ? 32'h1 : 32'h0);
        chk("done_lsu", {31'h0, lsu_done}, (w == W_LSU) ? 32'h1 : 32'h0);
        if (w == W_IF) begin
            chk("if_rdata", if_rdata, rdat);
            chk("lsu_rdata_hold", lsu_rdata, last_lsu);
            chk("stall_if_done", {31'h0, stall_if}, 32'h0);
            last_if = rdat;
            if_req = 1'b0;
        end else begin
            chk("lsu_rdata", lsu_rdata, rdat);
            chk("if_rdata_hold", if_rdata, last_if);
            chk("stall_lsu_done", {31'h0, stall_lsu}, 32'h0);
            last_lsu = rdat;
            lsu_req = 1'b0;
        end
        lat = cyc - t0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata = ~rdat;
        #1;
        chk("post_mem_req", {31'h0, mem_req}, 32'h0);
        chk("post_if_rdata", if_rdata, last_if);
        chk("post_lsu_rdata", lsu_rdata, last_lsu);
        chk_quiet("post");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int lat;
        reset = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_be = 4'h0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h0, 0, 0, 32'h0051_3093, W_IF, 2};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 4'b0011, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF, 3, 0, 32'h0000_0000, W_LSU, 5};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0000_0200, 32'h0, 1, 2, 32'hCAFE_F00D, W_LSU, 5};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0000_0300, 32'h0, 0, 0, 32'h1111_2222, W_LSU, 2};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0000_0020, 32'h0, 32'h0, 2, 1, 32'h00A0_0093, W_IF, 5};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 4'b1000, 32'h0, 32'h0000_03FC, 32'h0000_00AB, 0, 5, 32'h0000_0000, W_LSU, 7};

        // reset state, stall follows request during reset
        @(negedge clk);
        @(negedge clk);
        chk_reset_outs("rst0");
        if_req = 1'b1;
        #1;
        chk("rst0_stall_follow", {31'h0, stall_if}, 32'h1);
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // directed table
        for (int i = 0; i < 6; i++) begin
            if_req = tbl[i].use_if;
            if_addr = tbl[i].ia;
            lsu_req = tbl[i].use_lsu;
            lsu_we = tbl[i].we;
            lsu_be = tbl[i].be;
            lsu_addr = tbl[i].la;
            lsu_wdata = tbl[i].wd;
            serve(tbl[i].gd, tbl[i].rd, tbl[i].rdat, 1'b0, w, lat);
            chk($sformatf("vec%0d_winner", i), w, tbl[i].exp_w);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
        end

        // starvation: LSU wins four contests, then IF is forced through
        if_req = 1'b1;
        if_addr = 32'h0000_0080;
        for (int i = 0; i < 5; i++) begin
            lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'hF;
            lsu_addr = 32'h0000_0400 + 32'(i * 4);
            serve(0, 0, 32'hA000_0000 + 32'(i), 1'b0, w, lat);
            chk($sformatf("starve%0d_winner", i), w, (i < 4) ? W_LSU : W_IF);
        end
        serve(0, 0, 32'hA000_0010, 1'b0, w, lat);
        chk("starve_lsu_after", w, W_LSU);
        if_req = 1'b1; if_addr = 32'h0000_0084;
        lsu_req = 1'b1; lsu_addr = 32'h0000_0500;
        serve(0, 0, 32'hA000_0020, 1'b0, w, lat);
        chk("starve_cleared_winner", w, W_LSU);
        serve(0, 0, 32'hA000_0030, 1'b0, w, lat);
        chk("starve_cleared_if", w, W_IF);

        // LSU drops request during WAIT, response still consumed
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'hF; lsu_addr = 32'h0000_0600;
        serve(1, 2, 32'h1234_5678, 1'b1, w, lat);
        chk("drop_winner", w, W_LSU);

        // reset mid-ISSUE
        if_req = 1'b1; if_addr = 32'h0000_0040;
        @(negedge clk);
        chk("pre_rst_mem_req", {31'h0, mem_req}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_async_mem_req", {31'h0, mem_req}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_stall_if", {31'h0, stall_if}, 32'h1);
            chk("rst_hold_mem_req", {31'h0, mem_req}, 32'h0);
        end
        if_req = 1'b0;
        #1;
        chk_reset_outs("rst1");
        reset = 1'b0;
        model_starve = 0; last_if = 32'h0; last_lsu = 32'h0;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("spur_idle_if_done", {31'h0, if_done}, 32'h0);
        chk("spur_idle_lsu_done", {31'h0, lsu_done}, 32'h0);
        chk("spur_idle_if_rdata", if_rdata, 32'h0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("spur_idle_mem_req", {31'h0, mem_req}, 32'h0);

        // spurious rvalid in ISSUE, then gnt and rvalid together
        if_req = 1'b1; if_addr = 32'h0000_0044;
        @(negedge clk);
        mem_rvalid = 1'b1;
        #1;
        chk("spur_issue_if_done", {31'h0, if_done}, 32'h0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("spur_issue_mem_req", {31'h0, mem_req}, 32'h1);
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        #1;
        chk("gnt_rv_if_done", {31'h0, if_done}, 32'h0);
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk("gnt_rv_wait_done", {31'h0, if_done}, 32'h0);
        chk("gnt_rv_wait_mem_req", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h0F0F_0F0F;
        #1;
        chk("gnt_rv_done", {31'h0, if_done}, 32'h1);
        chk("gnt_rv_rdata", if_rdata, 32'h0F0F_0F0F);
        last_if = 32'h0F0F_0F0F;
        if_req = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk_quiet("gnt_rv_post");

        // random mixed traffic against the model
        for (int n = 0; n < 1000; n++) begin
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsu_req && $urandom_range(0, 1) == 1) begin
                lsu_req = 1'b1;
                lsu_we = 1'($urandom_range(0, 1));
                lsu_be = 4'($urandom_range(1, 15));
                lsu_addr = $urandom | 32'h0000_0001;
                lsu_wdata = $urandom;
            end
            if (!if_req && !lsu_req) begin
                if_req = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            serve($urandom_range(0, 5), $urandom_range(0, 5), $urandom,
                  ($urandom_range(0, 7) == 0), w, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
